// File: rtl/soc_system_timer_capture_arb.sv
// Round-robin arbiter sharing the timer PIO read port among NUM_REQ requesters.
// Each grant issues one read at address 0, captures the timestamp and returns it
// with the modular delta since that requester's previous capture.
module soc_system_timer_capture_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned IDLE_ADDR = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [1:0]         pio_address,
  input  logic [31:0]        pio_readdata,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [NUM_REQ-1:0] rsp_ack,
  output logic [31:0]        rsp_data,
  output logic [31:0]        rsp_delta,
  output logic               rsp_first,
  output logic               rsp_wrap,
  output logic [15:0]        drop_cnt
);

  localparam int unsigned TS_W   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 2;
  localparam logic [ADDR_W-1:0] IDLE_A = ADDR_W'(IDLE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t               state, state_next;
  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   clr_mask;
  logic [NUM_REQ-1:0]   drop_mask;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W-1:0]      sel_id;
  logic                 grant;
  logic [CNT_W:0]       drop_sum;
  logic [TS_W-1:0]      last_ts [NUM_REQ];
  logic [NUM_REQ-1:0]   last_valid;

  // Round-robin pick: lowest pending index above rr_ptr, else lowest at or below it.
  always_comb begin
    sel_id = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pending[i] && (ID_W'(i) <= rr_ptr)) sel_id = ID_W'(i);
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pending[i] && (ID_W'(i) > rr_ptr)) sel_id = ID_W'(i);
    end
  end

  // Next-state logic and grant decision.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    clr_mask   = '0;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          grant      = 1'b1;
          clr_mask   = NUM_REQ'(1) << sel_id;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE:   state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_RESP;
      S_RESP:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Drops: request on an id still pending that is not being granted this cycle.
  always_comb begin
    drop_mask = req & pending & ~clr_mask;
    drop_sum  = {1'b0, drop_cnt};
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      drop_sum = drop_sum + (CNT_W+1)'(drop_mask[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Pending bits (set wins over grant clear) and saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= (pending & ~clr_mask) | req;
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  // Grant latch, PIO address, capture and response datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      gnt_id      <= '0;
      pio_address <= IDLE_A;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_ack     <= '0;
      rsp_data    <= '0;
      rsp_delta   <= '0;
      rsp_first   <= 1'b0;
      rsp_wrap    <= 1'b0;
      last_valid  <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) last_ts[i] <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      pio_address <= (state_next == S_ISSUE) ? ADDR_W'(0) : IDLE_A;
      if (grant) begin
        gnt_id <= sel_id;
        rr_ptr <= sel_id;
      end
      case (state)
        S_CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_id    <= gnt_id;
          rsp_ack   <= NUM_REQ'(1) << gnt_id;
          rsp_data  <= pio_readdata;
          if (last_valid[gnt_id]) begin
            rsp_delta <= pio_readdata - last_ts[gnt_id];
            rsp_first <= 1'b0;
            rsp_wrap  <= (pio_readdata < last_ts[gnt_id]);
          end else begin
            rsp_delta <= '0;
            rsp_first <= 1'b1;
            rsp_wrap  <= 1'b0;
          end
        end
        S_RESP: begin
          rsp_ack             <= '0;
          last_ts[gnt_id]     <= rsp_data;
          last_valid[gnt_id]  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_timer_capture_arb.sv
// Randomized bench for the timer capture arbiter against a transaction-level
// model: a pending set, round-robin pointer, per-id capture history and the
// edge index of the latest grant.
module tb_soc_system_timer_capture_arb;

  localparam int N         = 4;
  localparam int ID_W      = 2;
  localparam int IDLE_ADDR = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [1:0]    pio_address;
  logic [31:0]   pio_readdata;
  logic          rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [N-1:0]  rsp_ack;
  logic [31:0]   rsp_data;
  logic [31:0]   rsp_delta;
  logic          rsp_first;
  logic          rsp_wrap;
  logic [15:0]   drop_cnt;

  soc_system_timer_capture_arb #(.NUM_REQ(N), .ID_W(ID_W), .IDLE_ADDR(IDLE_ADDR)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .pio_address(pio_address), .pio_readdata(pio_readdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ack(rsp_ack),
    .rsp_data(rsp_data), .rsp_delta(rsp_delta), .rsp_first(rsp_first),
    .rsp_wrap(rsp_wrap), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Model state.
  int          e = 0;        // clock edges seen with reset released
  int          g = -100;     // edge index of most recent grant
  int          gid = 0;
  int          rr = N - 1;
  int          drops = 0;
  bit [N-1:0]  pend = '0;
  bit          hv [N];
  logic [31:0] hts [N];
  logic [31:0] exp_ts = '0;
  logic [31:0] timer_val = '0;
  bit          rand_mode = 1'b0;
  logic [1:0]  addr_prev;

  int          got_ids [$];
  logic [31:0] l_data, l_delta;
  logic        l_first, l_wrap;
  int          id1_cnt;
  int          exp_rr [10] = '{0, 1, 2, 3, 0, 3, 0, 1, 2, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Compare DUT outputs against the model for the cycle following edge e.
  task automatic check_outputs();
    logic [31:0] ed;
    logic        ef, ew;
    chk("pio_address", 32'(pio_address), (e == g) ? 32'd0 : 32'(IDLE_ADDR));
    if (e == g + 2) begin
      if (hv[gid]) begin
        ed = exp_ts - hts[gid];
        ef = 1'b0;
        ew = (exp_ts < hts[gid]);
      end else begin
        ed = '0;
        ef = 1'b1;
        ew = 1'b0;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(gid));
      chk("rsp_ack", 32'(rsp_ack), 32'(1 << gid));
      chk("rsp_data", rsp_data, exp_ts);
      chk("rsp_delta", rsp_delta, ed);
      chk("rsp_first", 32'(rsp_first), 32'(ef));
      chk("rsp_wrap", 32'(rsp_wrap), 32'(ew));
      hv[gid]  = 1'b1;
      hts[gid] = exp_ts;
      got_ids.push_back(int'(rsp_id));
      l_data  = rsp_data;
      l_delta = rsp_delta;
      l_first = rsp_first;
      l_wrap  = rsp_wrap;
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      chk("rsp_ack_idle", 32'(rsp_ack), 32'd0);
    end
    chk("drop_cnt", 32'(drop_cnt), 32'(drops));
  endtask

  // Model reaction to one clock edge with request vector r.
  task automatic model_edge(input bit [N-1:0] r);
    int gnt;
    int id;
    gnt = -1;
    if (e >= g + 4 && pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        id = (rr + k) % N;
        if (gnt < 0 && pend[id]) gnt = id;
      end
      g   = e;
      gid = gnt;
      rr  = gnt;
    end
    for (int i = 0; i < N; i++) begin
      if (r[i] && pend[i] && i != gnt && drops < 65535) drops++;
    end
    if (gnt >= 0) pend[gnt] = 1'b0;
    pend = pend | r;
  endtask

  // One clock cycle: check, drive req for the coming edge, emulate the PIO.
  task automatic step(input bit [N-1:0] r);
    @(negedge clk);
    check_outputs();
    req       = r;
    addr_prev = pio_address;
    @(posedge clk);
    e++;
    model_edge(r);
    #1;
    if (rand_mode && $urandom_range(0, 3) != 0) timer_val = $urandom;
    pio_readdata = (addr_prev == 2'd0) ? timer_val : 32'd0;
    if (e == g + 1) exp_ts = timer_val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ack", 32'(rsp_ack), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_delta", rsp_delta, 32'd0);
    chk("rst_first_wrap", 32'({rsp_first, rsp_wrap}), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_addr", 32'(pio_address), 32'(IDLE_ADDR));
    pend  = '0;
    g     = -100;
    rr    = N - 1;
    drops = 0;
    for (int i = 0; i < N; i++) begin
      hv[i]  = 1'b0;
      hts[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    req          = '0;
    pio_readdata = '0;
    do_reset();

    // Single request.
    timer_val = 32'h0000_1000;
    got_ids.delete();
    step(4'b0001);
    repeat (6) step(4'b0000);
    chk("single_count", 32'(got_ids.size()), 32'd1);
    chk("single_data", l_data, 32'h0000_1000);
    chk("single_first", 32'(l_first), 32'd1);
    chk("single_delta", l_delta, 32'd0);

    // Delta and wrap on id2.
    do_reset();
    timer_val = 32'hFFFF_FFF0;
    step(4'b0100);
    repeat (6) step(4'b0000);
    timer_val = 32'h0000_0010;
    step(4'b0100);
    repeat (6) step(4'b0000);
    chk("wrap_delta", l_delta, 32'h20);
    chk("wrap_flag", 32'(l_wrap), 32'd1);
    chk("wrap_first", 32'(l_first), 32'd0);
    timer_val = 32'h0000_0110;
    step(4'b0100);
    repeat (6) step(4'b0000);
    chk("nowrap_delta", l_delta, 32'h100);
    chk("nowrap_flag", 32'(l_wrap), 32'd0);

    // Round robin order.
    do_reset();
    got_ids.delete();
    step(4'b1111);
    repeat (20) step(4'b0000);
    step(4'b1001);
    repeat (12) step(4'b0000);
    step(4'b1111);
    repeat (20) step(4'b0000);
    chk("rr_count", 32'(got_ids.size()), 32'd10);
    for (int i = 0; i < 10 && i < got_ids.size(); i++) chk("rr_order", 32'(got_ids[i]), 32'(exp_rr[i]));

    // Drop counting.
    do_reset();
    got_ids.delete();
    step(4'b0001);
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);
    repeat (12) step(4'b0000);
    chk("drop_two", 32'(drop_cnt), 32'd2);
    id1_cnt = 0;
    foreach (got_ids[i]) if (got_ids[i] == 1) id1_cnt++;
    chk("drop_id1_once", 32'(id1_cnt), 32'd1);
    got_ids.delete();
    step(4'b0010);
    step(4'b0010);
    repeat (14) step(4'b0000);
    chk("grant_req_nodrop", 32'(drop_cnt), 32'd2);
    chk("grant_req_twice", 32'(got_ids.size()), 32'd2);

    // Reset during CAPTURE.
    do_reset();
    step(4'b0001);
    step(4'b0010);
    step(4'b0010);
    do_reset();
    got_ids.delete();
    repeat (8) step(4'b0000);
    chk("abort_no_rsp", 32'(got_ids.size()), 32'd0);
    timer_val = 32'h0000_2000;
    step(4'b0001);
    repeat (6) step(4'b0000);
    chk("abort_first", 32'(l_first), 32'd1);

    // Randomized traffic.
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) step(N'($urandom & $urandom));
    rand_mode = 1'b0;
    repeat (8) step(4'b0000);

    // Drop counter saturation.
    do_reset();
    repeat (20000) step(4'b1111);
    step(4'b0000);
    chk("drop_saturate", 32'(drop_cnt), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/soc_system_timer_capture_arb.md
Name: soc_system_timer_capture_arb

Overview:
- Shares the 32-bit free-running timer PIO read port among NUM_REQ hardware requesters, e.g. encoder, sonar and odometry sample triggers.
- Arbitrates round-robin, sequences a single Avalon-MM read (address 0, one-cycle registered read latency) per grant.
- Returns each requester's timestamp plus the modular delta since that requester's previous capture.
- Sits between the timer PIO slave and the FPGA-side capture logic; the CPU HPS path is unaffected.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; 2**ID_W >= NUM_REQ.
- IDLE_ADDR, 1, PIO address driven when not issuing a read (non-zero, so the PIO returns 0).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester single-cycle capture request pulse.
- pio_address  out  2  address to the timer PIO slave.
- pio_readdata  in  32  PIO readdata; registered, valid one cycle after address.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_W  index of the requester served.
- rsp_ack  out  NUM_REQ  one-hot copy of rsp_id, asserted with rsp_valid.
- rsp_data  out  32  captured timestamp.
- rsp_delta  out  32  rsp_data minus previous capture for the same id, mod 2^32.
- rsp_first  out  1  first capture for this id since reset; rsp_delta is 0.
- rsp_wrap  out  1  rsp_data < previous capture (unsigned); timer wrapped.
- drop_cnt  out  16  saturating count of req pulses that hit an already-pending id.

Behaviour:
- Reset (async, reset_n=0):
  - pending=0, last_ts=0, last_valid=0, rr_ptr=NUM_REQ-1, state=IDLE.
  - All rsp_* outputs = 0, drop_cnt=0, pio_address=IDLE_ADDR.
- Pending bits:
  - req[i] sets pending[i].
  - req[i] while pending[i] is already 1 is ignored, and drop_cnt increments (saturates at 0xFFFF).
  - A grant clears pending[i]; a req[i] pulse in the same cycle as its grant sets pending[i] again (set wins) and is not counted as a drop.
- FSM (registered state, one grant per 4 cycles):
  - IDLE: if pending != 0, pick the first set bit searching from rr_ptr+1 upward with wrap, latch it as gnt_id, set rr_ptr=gnt_id, clear pending[gnt_id] -> ISSUE. Else stay in IDLE.
  - ISSUE: pio_address = 0 for this cycle only -> CAPTURE.
  - CAPTURE: register pio_readdata into ts; compute delta/first/wrap from last_ts[gnt_id], last_valid[gnt_id] -> RESP.
  - RESP: rsp_valid=1, rsp_ack[gnt_id]=1 for exactly this cycle; update last_ts[gnt_id]=ts, last_valid[gnt_id]=1 -> IDLE.
- pio_address = IDLE_ADDR in every state except ISSUE.
- Latency: pulse req at cycle n with the FSM idle and no competitors -> pending visible in n+1 IDLE -> ISSUE n+2, CAPTURE n+3, rsp_valid n+4.
- rsp_data/rsp_id/rsp_delta/rsp_first/rsp_wrap hold their values after rsp_valid drops until the next RESP; consumers may only sample them on rsp_valid.
- Arithmetic:
  - rsp_delta = ts - last_ts, 32-bit modular.
  - First capture for an id: delta=0, first=1, wrap=0.
  - Equal timestamps: delta=0, wrap=0.
- Requests arriving during ISSUE/CAPTURE/RESP only set pending; they never preempt the current grant.
- Reset asserted mid-transaction aborts with no response; all history is lost.

Test Plan:
- Single request: req=0001 pulse, pio_readdata=0x0000_1000 in the CAPTURE cycle -> 4 cycles later rsp_valid=1, rsp_id=0, rsp_ack=0001, rsp_data=0x1000, rsp_first=1, rsp_delta=0. pio_address is 0 only in the ISSUE cycle, otherwise 1.
- Delta and wrap: id2 captures 0xFFFF_FFF0, then 0x0000_0010 -> second response has rsp_delta=0x20, rsp_wrap=1, rsp_first=0. A third capture of 0x0000_0110 gives delta=0x100, wrap=0.
- Round robin: req=1111 in one cycle after reset -> grants in order 0,1,2,3 at 4-cycle spacing. Then req=1001 -> 0 then 3. Then req=1111 again -> 0,1,2,3, since rr_ptr=3 after last grant 3.
- Drop counting: pulse req[1] three times while id1 is pending and the FSM is busy serving id0 -> drop_cnt=2, exactly one id1 response. A req[1] pulse in id1's grant cycle yields a second id1 response and no drop.
- Reset mid-operation: assert reset_n=0 during CAPTURE -> no rsp_valid, pending=0, drop_cnt=0. The next capture for the same id reports rsp_first=1.
- Saturation: 70000 drop events -> drop_cnt holds at 0xFFFF.
